// File: rtl/dm_arbiter_pkg.sv
// Shared constants for the data-memory arbiter.
//   dm_arb_state_t : arbiter FSM encoding
//   DM_PORT_CPU    : grant index of the CPU load/store port (port 0)
//   DM_PORT_DBG    : grant index of the loader/debug port (port 1)
package dm_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } dm_arb_state_t;

   localparam logic DM_PORT_CPU = 1'b0;
   localparam logic DM_PORT_DBG = 1'b1;

endpackage

// File: rtl/dm_arb_rr_pick.sv
// Combinational two-way round-robin pick.
//   req[1:0]    in  : request per port
//   last_grant  in  : port granted most recently
//   grant_valid out : at least one request present
//   grant_idx   out : winning port; a lone requester wins, a tie goes to
//                     the port that was not granted last
module dm_arb_rr_pick
   import dm_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_idx
);

   always_comb begin
      grant_valid = |req;
      grant_idx   = DM_PORT_CPU;
      if (req == 2'b10) begin
         grant_idx = DM_PORT_DBG;
      end else if (req == 2'b11) begin
         grant_idx = ~last_grant;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the single data memory.
// Port 0 is the CPU load/store path, port 1 the loader/debug port. One
// transaction is in flight at a time; ACK/RDATA are registered per port.
// Ports:
//   CLK, RESET_N                 clock, async active-low reset
//   REQn/WEn/ADDRn/WDATAn        request side of port n (held while REQn)
//   ACKn/RDATAn                  one-cycle completion pulse, read data
//   DM_EN/DM_WE/DM_ADDR/DM_WDATA registered memory command
//   DM_RDATA/DM_READY            memory response
//   BUSY                         arbiter not idle
//   ERR                          watchdog abort, coincident with ACKn
// Build option: define DM_ARB_WATCHDOG_EN to abort an ACCESS that sees no
// DM_READY within WDOG_CYCLES cycles. Without it ACCESS waits forever and
// ERR stays 0.
//
// state      | meaning
// -----------+------------------------------------------------------
// ARB_IDLE   | no transaction; pick a winner when any REQ is high
// ARB_ACCESS | DM_EN high with latched command, wait for DM_READY
// ARB_RESP   | ACK pulse to the granted port, memory released
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 19,
   parameter int DATA_W      = 19,
   parameter int WDOG_CYCLES = 16
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              REQ0,
   input  logic              WE0,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [DATA_W-1:0] WDATA0,
   output logic              ACK0,
   output logic [DATA_W-1:0] RDATA0,
   input  logic              REQ1,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [DATA_W-1:0] WDATA1,
   output logic              ACK1,
   output logic [DATA_W-1:0] RDATA1,
   output logic              DM_EN,
   output logic              DM_WE,
   output logic [ADDR_W-1:0] DM_ADDR,
   output logic [DATA_W-1:0] DM_WDATA,
   input  logic [DATA_W-1:0] DM_RDATA,
   input  logic              DM_READY,
   output logic              BUSY,
   output logic              ERR
);

   dm_arb_state_t     state, state_d;
   logic              grant_valid, grant_idx;
   logic              last_grant, gnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              latch_en, rd_cap, abort, wdog_expire;
   logic              dm_en_q, dm_we_q, ack0_q, ack1_q, err_q, busy_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   dm_arb_rr_pick u_pick (
      .req         ({REQ1, REQ0}),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign sel_we    = (grant_idx == DM_PORT_DBG) ? WE1    : WE0;
   assign sel_addr  = (grant_idx == DM_PORT_DBG) ? ADDR1  : ADDR0;
   assign sel_wdata = (grant_idx == DM_PORT_DBG) ? WDATA1 : WDATA0;

`ifdef DM_ARB_WATCHDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   // Counter holds (ACCESS cycles elapsed - 1); terminal value marks the last allowed cycle.
   localparam logic [WDOG_W-1:0] WDOG_TC = WDOG_W'(WDOG_CYCLES - 1);
   logic [WDOG_W-1:0] wdog_cnt;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wdog_cnt <= '0;
      end else if (latch_en) begin
         wdog_cnt <= '0;
      end else if (state == ARB_ACCESS) begin
         wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end
   end

   assign wdog_expire = (state == ARB_ACCESS) && (wdog_cnt == WDOG_TC);
`else
   assign wdog_expire = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d  = state;
      latch_en = 1'b0;
      rd_cap   = 1'b0;
      abort    = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (grant_valid) begin
               latch_en = 1'b1;
               state_d  = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            // A READY on the terminal watchdog cycle completes normally.
            if (DM_READY) begin
               rd_cap  = ~we_q;
               state_d = ARB_RESP;
            end else if (wdog_expire) begin
               abort   = 1'b1;
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   // All memory/handshake outputs come straight from flops, computed from state_d.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         last_grant <= DM_PORT_DBG;
         gnt_q      <= DM_PORT_CPU;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         dm_en_q    <= 1'b0;
         dm_we_q    <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         dm_en_q <= (state_d == ARB_ACCESS);
         busy_q  <= (state_d != ARB_IDLE);
         ack0_q  <= (state_d == ARB_RESP) && (gnt_q == DM_PORT_CPU);
         ack1_q  <= (state_d == ARB_RESP) && (gnt_q == DM_PORT_DBG);
         err_q   <= abort;
         if (latch_en) begin
            gnt_q      <= grant_idx;
            last_grant <= grant_idx;
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            dm_we_q    <= sel_we;
         end else if (state_d != ARB_ACCESS) begin
            dm_we_q    <= 1'b0;
         end
         if (rd_cap || abort) begin
            if (gnt_q == DM_PORT_CPU) begin
               rdata0_q <= abort ? '0 : DM_RDATA;
            end else begin
               rdata1_q <= abort ? '0 : DM_RDATA;
            end
         end
      end
   end

   assign DM_EN    = dm_en_q;
   assign DM_WE    = dm_we_q;
   assign DM_ADDR  = addr_q;
   assign DM_WDATA = wdata_q;
   assign ACK0     = ack0_q;
   assign ACK1     = ack1_q;
   assign RDATA0   = rdata0_q;
   assign RDATA1   = rdata1_q;
   assign BUSY     = busy_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, so each tick() advances one cycle.
module tb_dm_arbiter;

   logic        CLK, RESET_N;
   logic        REQ0, WE0, REQ1, WE1;
   logic [18:0] ADDR0, WDATA0, ADDR1, WDATA1;
   logic        ACK0, ACK1;
   logic [18:0] RDATA0, RDATA1;
   logic        DM_EN, DM_WE, DM_READY, BUSY, ERR;
   logic [18:0] DM_ADDR, DM_WDATA, DM_RDATA;

   int total = 0;
   int bad   = 0;

   dm_arbiter dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .ACK0(ACK0), .RDATA0(RDATA0),
      .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .ACK1(ACK1), .RDATA1(RDATA1),
      .DM_EN(DM_EN), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
      .DM_RDATA(DM_RDATA), .DM_READY(DM_READY), .BUSY(BUSY), .ERR(ERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      RESET_N = 1'b0;
      REQ0 = 0; WE0 = 0; ADDR0 = '0; WDATA0 = '0;
      REQ1 = 0; WE1 = 0; ADDR1 = '0; WDATA1 = '0;
      DM_READY = 0; DM_RDATA = '0;
      tick(); tick();
      chk("rst_ack0", ACK0, 0);
      chk("rst_ack1", ACK1, 0);
      chk("rst_dm_en", DM_EN, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_err", ERR, 0);
      chk("rst_rdata0", RDATA0, 0);
      chk("rst_rdata1", RDATA1, 0);
      chk("rst_dm_addr", DM_ADDR, 0);
      RESET_N = 1'b1;
      tick();
      chk("idle_busy", BUSY, 0);

      // Port 0 read, memory answers in the first ACCESS cycle.
      REQ0 = 1; WE0 = 0; ADDR0 = 19'h00005;
      tick();
      chk("rd0_dm_en", DM_EN, 1);
      chk("rd0_dm_we", DM_WE, 0);
      chk("rd0_dm_addr", DM_ADDR, 19'h00005);
      chk("rd0_busy", BUSY, 1);
      chk("rd0_ack_early", ACK0, 0);
      DM_READY = 1; DM_RDATA = 19'h0ABCD;
      tick();
      chk("rd0_ack", ACK0, 1);
      chk("rd0_rdata", RDATA0, 19'h0ABCD);
      chk("rd0_dm_en_off", DM_EN, 0);
      REQ0 = 0; DM_READY = 0;
      tick();
      chk("rd0_ack_one_cycle", ACK0, 0);
      chk("rd0_idle", BUSY, 0);

      // Port 0 write, READY in the same cycle as DM_EN: ACK two cycles after REQ sampled.
      REQ0 = 1; WE0 = 1; ADDR0 = 19'h00010; WDATA0 = 19'h7FFFF;
      tick();
      chk("wr0_dm_en", DM_EN, 1);
      chk("wr0_dm_we", DM_WE, 1);
      chk("wr0_dm_addr", DM_ADDR, 19'h00010);
      chk("wr0_dm_wdata", DM_WDATA, 19'h7FFFF);
      chk("wr0_ack_c1", ACK0, 0);
      DM_READY = 1; DM_RDATA = 19'h55555;
      tick();
      chk("wr0_ack_c2", ACK0, 1);
      chk("wr0_ack1", ACK1, 0);
      chk("wr0_rdata_kept", RDATA0, 19'h0ABCD);
      chk("wr0_dm_we_off", DM_WE, 0);
      REQ0 = 0; WE0 = 0; DM_READY = 0;
      tick();

      // Port 1 read, READY three cycles late: DM_EN high four cycles.
      REQ1 = 1; WE1 = 0; ADDR1 = 19'h00010;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("rd1_dm_en_wait", DM_EN, 1);
         chk("rd1_ack_wait", ACK1, 0);
         tick();
      end
      chk("rd1_dm_en_c4", DM_EN, 1);
      chk("rd1_dm_addr", DM_ADDR, 19'h00010);
      DM_READY = 1; DM_RDATA = 19'h12345;
      tick();
      chk("rd1_ack", ACK1, 1);
      chk("rd1_ack0", ACK0, 0);
      chk("rd1_rdata", RDATA1, 19'h12345);
      chk("rd1_rdata0_kept", RDATA0, 19'h0ABCD);
      REQ1 = 0; DM_READY = 0;
      tick();

      // Reset in the middle of an ACCESS drops the transaction.
      REQ1 = 1; WE1 = 1; ADDR1 = 19'h00077; WDATA1 = 19'h00123;
      tick();
      chk("mid_dm_en", DM_EN, 1);
      RESET_N = 0;
      #2;
      chk("mid_rst_dm_en", DM_EN, 0);
      chk("mid_rst_dm_we", DM_WE, 0);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_rdata1", RDATA1, 0);
      chk("mid_rst_addr", DM_ADDR, 0);
      REQ1 = 0; WE1 = 0;
      RESET_N = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_ack1", ACK1, 0);
         chk("post_rst_busy", BUSY, 0);
      end

      // Both ports held: grants alternate starting with port 0.
      REQ0 = 1; WE0 = 0; ADDR0 = 19'h00100;
      REQ1 = 1; WE1 = 0; ADDR1 = 19'h00200;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rr_dm_en", DM_EN, 1);
         chk("rr_dm_addr", DM_ADDR, (k % 2 == 0) ? 19'h00100 : 19'h00200);
         DM_READY = 1; DM_RDATA = 19'h01000 + 19'(k);
         tick();
         chk("rr_ack0", ACK0, (k % 2 == 0) ? 1 : 0);
         chk("rr_ack1", ACK1, (k % 2 == 1) ? 1 : 0);
         if (k % 2 == 0) chk("rr_rdata0", RDATA0, 19'h01000 + 19'(k));
         else            chk("rr_rdata1", RDATA1, 19'h01000 + 19'(k));
         DM_READY = 0;
         tick();
      end
      REQ0 = 0; REQ1 = 0;
      tick();
      chk("rr_idle", BUSY, 0);

      // No READY at all for 16 ACCESS cycles.
      REQ0 = 1; WE0 = 0; ADDR0 = 19'h00033;
      tick();
      for (int i = 0; i < 16; i++) begin
         chk("wd_dm_en", DM_EN, 1);
         chk("wd_err_early", ERR, 0);
         chk("wd_ack_early", ACK0, 0);
         tick();
      end
`ifdef DM_ARB_WATCHDOG_EN
      chk("wd_ack", ACK0, 1);
      chk("wd_err", ERR, 1);
      chk("wd_rdata0", RDATA0, 0);
      chk("wd_dm_en_off", DM_EN, 0);
      REQ0 = 0;
      tick();
      chk("wd_err_pulse", ERR, 0);
      chk("wd_idle", BUSY, 0);
`else
      chk("nowd_busy", BUSY, 1);
      chk("nowd_err", ERR, 0);
      chk("nowd_ack", ACK0, 0);
      chk("nowd_dm_en", DM_EN, 1);
      DM_READY = 1; DM_RDATA = 19'h00777;
      tick();
      chk("nowd_late_ack", ACK0, 1);
      chk("nowd_late_rdata", RDATA0, 19'h00777);
      REQ0 = 0; DM_READY = 0;
      tick();
      chk("nowd_idle", BUSY, 0);
`endif
      tick();

      // READY arriving on the 16th ACCESS cycle completes normally.
      REQ0 = 1; WE0 = 0; ADDR0 = 19'h00044;
      tick();
      for (int i = 0; i < 15; i++) begin
         chk("tc_dm_en", DM_EN, 1);
         tick();
      end
      chk("tc_dm_en_16", DM_EN, 1);
      DM_READY = 1; DM_RDATA = 19'h2468A;
      tick();
      chk("tc_ack", ACK0, 1);
      chk("tc_err", ERR, 0);
      chk("tc_rdata0", RDATA0, 19'h2468A);
      REQ0 = 0; DM_READY = 0;
      tick();
      chk("tc_idle", BUSY, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
